// File: rtl/ram_bus_ctrl_if.sv
// Request/response handshake bundle between a client and ram_bus_ctrl.
// master = requester, slave = controller.
interface ram_bus_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              wr_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, wr_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, wr_done
   );
endinterface

// File: rtl/ram_bus_ctrl.sv
// Request-side sequencer for the 32x5 sync-read/sync-write RAM.
// Owns every RAM pin; one IDLE cycle always separates bus owners.
module ram_bus_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_bus_ctrl_if.slave     bus,
   output logic [ADDR_W-1:0] mem_address,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic              mem_cs,
   output logic              mem_we,
   output logic              mem_oe
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR   = 2'd1;
   localparam logic [1:0] RD   = 2'd2;
   localparam logic [1:0] CAP  = 2'd3;

   logic [1:0]        state;
   logic [DATA_W-1:0] wdata;
   logic              accept;

   // Gated by rst_n so nothing is offered while reset is held.
   assign bus.req_ready = rst_n & (state == IDLE);
   assign accept        = bus.req_valid & bus.req_ready;

   // Drive the bus only during the write cycle; z otherwise.
   assign mem_data = (mem_we & ~mem_oe) ? wdata : {DATA_W{1'bz}};

   // Main sequencer: registered RAM controls and response pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wdata         <= '0;
         mem_address   <= '0;
         mem_cs        <= 1'b0;
         mem_we        <= 1'b0;
         mem_oe        <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.wr_done   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.wr_done   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mem_address <= bus.req_addr;
                  mem_cs      <= 1'b1;
                  if (bus.req_we) begin
                     state  <= WR;
                     wdata  <= bus.req_wdata;
                     mem_we <= 1'b1;
                     mem_oe <= 1'b0;
                  end else begin
                     state  <= RD;
                     mem_we <= 1'b0;
                     mem_oe <= 1'b1;
                  end
               end
            end
            WR: begin
               state       <= IDLE;
               mem_cs      <= 1'b0;
               mem_we      <= 1'b0;
               bus.wr_done <= 1'b1;
            end
            RD: begin
               state <= CAP;
            end
            CAP: begin
               state         <= IDLE;
               mem_cs        <= 1'b0;
               mem_oe        <= 1'b0;
               bus.rsp_rdata <= mem_data;
               bus.rsp_valid <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Directed bench for ram_bus_ctrl with a behavioural 32x5 RAM.
// Drives and samples on the falling edge.
module tb_ram_bus_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] mem_address;
   wire  [4:0] mem_data;
   logic       mem_cs;
   logic       mem_we;
   logic       mem_oe;

   ram_bus_ctrl_if #(.ADDR_W(5), .DATA_W(5)) bus ();

   ram_bus_ctrl #(.ADDR_W(5), .DATA_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_cs      (mem_cs),
      .mem_we      (mem_we),
      .mem_oe      (mem_oe)
   );

   logic [4:0] ram [32];
   logic [4:0] ram_q;
   logic       ram_drv;
   logic       bus_z;

   assign ram_drv  = mem_cs & mem_oe & ~mem_we;
   assign mem_data = ram_drv ? ram_q : 5'bzzzzz;
   assign bus_z    = (mem_data === 5'bzzzzz);

   // RAM write port
   always @(posedge clk)
      if (mem_cs && mem_we) ram[mem_address] <= mem_data;

   // RAM registered read port
   always @(posedge clk)
      if (ram_drv) ram_q <= ram[mem_address];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_err;
   int acc_cnt;
   int rsp_cnt;
   int both_cnt;
   int x_cnt;

   initial begin
      acc_cnt  = 0;
      rsp_cnt  = 0;
      both_cnt = 0;
      x_cnt    = 0;
   end

   // Count handshakes and response pulses
   always @(posedge clk) begin
      if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
      if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   // Watch for overlapping pulses and bus conflicts
   always @(negedge clk) begin
      if (bus.rsp_valid && bus.wr_done) both_cnt <= both_cnt + 1;
      if ($isunknown(mem_data) && !bus_z) x_cnt <= x_cnt + 1;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_wr(input logic [4:0] a, input logic [4:0] d);
      check("wr_rdy", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("wr_we", mem_we, 1);
      check("wr_cs", mem_cs, 1);
      check("wr_oe", mem_oe, 0);
      check("wr_addr", mem_address, a);
      check("wr_bus", mem_data, d);
      check("wr_done_early", bus.wr_done, 0);
      check("wr_busy", bus.req_ready, 0);
      @(negedge clk);
      check("wr_done", bus.wr_done, 1);
      check("wr_we_off", mem_we, 0);
      check("wr_cs_off", mem_cs, 0);
      check("wr_ram", ram[a], d);
      check("wr_bus_rel", bus_z, 1);
      check("wr_idle_rdy", bus.req_ready, 1);
      @(negedge clk);
      check("wr_done_end", bus.wr_done, 0);
   endtask

   task automatic do_rd(input logic [4:0] a, input logic [4:0] e);
      check("rd_rdy", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = a;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("rd_oe", mem_oe, 1);
      check("rd_cs", mem_cs, 1);
      check("rd_we", mem_we, 0);
      check("rd_addr", mem_address, a);
      check("rd_busy", bus.req_ready, 0);
      check("rd_rsp_e1", bus.rsp_valid, 0);
      @(negedge clk);
      check("rd_rsp_e2", bus.rsp_valid, 0);
      check("rd_bus", mem_data, e);
      @(negedge clk);
      check("rd_rsp", bus.rsp_valid, 1);
      check("rd_data", bus.rsp_rdata, e);
      check("rd_oe_off", mem_oe, 0);
      check("rd_cs_off", mem_cs, 0);
      check("rd_idle_rdy", bus.req_ready, 1);
      @(negedge clk);
      check("rd_rsp_end", bus.rsp_valid, 0);
      check("rd_hold", bus.rsp_rdata, e);
   endtask

   int acc0;
   int rsp0;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      // 1: reset state
      repeat (3) @(negedge clk);
      check("rst_rdy", bus.req_ready, 0);
      check("rst_cs", mem_cs, 0);
      check("rst_we", mem_we, 0);
      check("rst_oe", mem_oe, 0);
      check("rst_addr", mem_address, 0);
      check("rst_bus_z", bus_z, 1);
      check("rst_rsp", bus.rsp_valid, 0);
      check("rst_rdata", bus.rsp_rdata, 0);
      check("rst_wrd", bus.wr_done, 0);
      rst_n = 1'b1;
      #1;
      check("rel_rdy", bus.req_ready, 1);
      @(negedge clk);

      // 2, 3: write then read back
      do_wr(5'd11, 5'd15);
      do_rd(5'd11, 5'd15);

      // 4: alternating traffic at the top address
      do_wr(5'd31, 5'h1F);
      do_rd(5'd31, 5'd31);
      do_wr(5'd31, 5'h0A);
      do_rd(5'd31, 5'd10);

      // 5: request held high across a busy read
      acc0 = acc_cnt;
      rsp0 = rsp_cnt;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 5'd11;
      @(posedge clk);
      @(negedge clk);
      check("stall_rd", bus.req_ready, 0);
      @(negedge clk);
      check("stall_cap", bus.req_ready, 0);
      check("stall_rsp0", bus.rsp_valid, 0);
      @(negedge clk);
      check("stall_idle", bus.req_ready, 1);
      check("stall_rsp", bus.rsp_valid, 1);
      check("stall_data", bus.rsp_rdata, 15);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("stall_2nd", mem_oe, 1);
      repeat (4) @(negedge clk);
      check("stall_acc", acc_cnt - acc0, 2);
      check("stall_rsps", rsp_cnt - rsp0, 2);
      check("stall_rdy", bus.req_ready, 1);

      // 6: reset pulse in the middle of a write
      do_wr(5'd3, 5'd0);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 5'd3;
      bus.req_wdata = 5'd7;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      check("abort_we", mem_we, 0);
      check("abort_cs", mem_cs, 0);
      check("abort_bus_z", bus_z, 1);
      check("abort_rdy", bus.req_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_ram", ram[3], 0);
      check("abort_wrd", bus.wr_done, 0);
      @(negedge clk);
      check("abort_wrd2", bus.wr_done, 0);
      check("abort_rdy2", bus.req_ready, 1);
      do_rd(5'd3, 5'd0);

      check("no_overlap", both_cnt, 0);
      check("bus_x", x_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
